// File: rtl/alu_regfile_pipe.sv
// Two-stage execute unit: register file with write-back forwarding feeding a
// registered ALU with N/Z/C/V flags and a valid/ready result stage.
module alu_regfile_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic            w_en,
    input  logic            imm_en,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic [3:0]      flags,
    output logic [AW-1:0]   res_rd,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] regs [NREG];

    logic            vld_p1;
    logic            wen_p1;
    logic [XLEN-1:0] res_p1;
    logic [3:0]      flags_p1;
    logic [AW-1:0]   rd_p1;

    logic            issue;
    logic            retire;
    logic            commit;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic            alu_c;
    logic            alu_v;
    logic [XLEN:0]   sum_ext;
    logic [XLEN:0]   diff_ext;
    logic [SW-1:0]   shamt;
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    // Signed overflow from operand/result sign bits; for subtraction B's sign is inverted.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        logic b_eff;
        b_eff = b_msb ^ is_sub;
        return (a_msb == b_eff) && (r_msb != a_msb);
    endfunction

    assign in_ready = !vld_p1 || out_ready;
    assign issue    = in_valid && in_ready;
    assign retire   = vld_p1 && out_ready;
    assign commit   = retire && wen_p1 && (rd_p1 != '0);

    // Stage 1: operand select with forwarding of the result retiring this cycle
    assign op_a = (rs1 == '0) ? '0 : (commit && rd_p1 == rs1) ? res_p1 : regs[rs1];
    assign op_b = imm_en ? imm :
                  (rs2 == '0) ? '0 : (commit && rd_p1 == rs2) ? res_p1 : regs[rs2];

    assign a_s      = op_a;
    assign b_s      = op_b;
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
    assign shamt    = op_b[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op)
            4'd0: begin
                alu_res = sum_ext[XLEN-1:0];
                alu_c   = sum_ext[XLEN];
                alu_v   = signed_ovf(op_a[XLEN-1], op_b[XLEN-1], sum_ext[XLEN-1], 1'b0);
            end
            4'd1: begin
                alu_res = diff_ext[XLEN-1:0];
                alu_c   = diff_ext[XLEN];
                alu_v   = signed_ovf(op_a[XLEN-1], op_b[XLEN-1], diff_ext[XLEN-1], 1'b1);
            end
            4'd2: alu_res = op_a << shamt;
            4'd3: alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            4'd4: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            4'd5: alu_res = op_a ^ op_b;
            4'd6: alu_res = op_a >> shamt;
            4'd7: alu_res = a_s >>> shamt;
            4'd8: alu_res = op_a | op_b;
            4'd9: alu_res = op_a & op_b;
            default: alu_res = '0;
        endcase
    end

    // Stage 2: held result, flags and write-back target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            wen_p1   <= 1'b0;
            res_p1   <= '0;
            flags_p1 <= '0;
            rd_p1    <= '0;
        end else if (issue) begin
            vld_p1   <= 1'b1;
            wen_p1   <= w_en;
            res_p1   <= alu_res;
            flags_p1 <= {alu_res[XLEN-1], (alu_res == '0), alu_c, alu_v};
            rd_p1    <= rd;
        end else if (retire) begin
            vld_p1   <= 1'b0;
        end
    end

    // Write-back at retire; register 0 is never written so it always reads zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[rd_p1] <= res_p1;
        end
    end

    assign out_valid = vld_p1;
    assign res       = res_p1;
    assign flags     = flags_p1;
    assign res_rd    = rd_p1;
    assign dbg_data  = regs[dbg_addr];
endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Bench for alu_regfile_pipe: arithmetic reference model with a per-cycle
// comparator, directed literal cases, randomized traffic and an 8-bit instance.
module tb_alu_regfile_pipe;
    logic clk;
    logic rst;

    logic        in_valid, in_ready, w_en, imm_en, out_valid, out_ready;
    logic [3:0]  alu_op, flags;
    logic [4:0]  rs1, rs2, rd, res_rd, dbg_addr;
    logic [31:0] imm, res, dbg_data;

    logic       s_in_valid, s_in_ready, s_w_en, s_imm_en, s_out_valid, s_out_ready;
    logic [3:0] s_alu_op, s_flags;
    logic [1:0] s_rs1, s_rs2, s_rd, s_res_rd, s_dbg_addr;
    logic [7:0] s_imm, s_res, s_dbg_data;

    int checks = 0;
    int errors = 0;

    alu_regfile_pipe #(.XLEN(32), .NREG(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .w_en(w_en),
        .imm_en(imm_en), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .flags(flags), .res_rd(res_rd), .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    alu_regfile_pipe #(.XLEN(8), .NREG(4)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .alu_op(s_alu_op), .rs1(s_rs1), .rs2(s_rs2), .rd(s_rd), .w_en(s_w_en),
        .imm_en(s_imm_en), .imm(s_imm), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .res(s_res), .flags(s_flags), .res_rd(s_res_rd), .dbg_addr(s_dbg_addr),
        .dbg_data(s_dbg_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic; returns {result, N, Z, C, V}.
    function automatic logic [67:0] ref_alu(input int w, input logic [3:0] op,
                                            input longint unsigned a, input longint unsigned b);
        longint unsigned mask, r;
        longint hs, sa, sb, s;
        int sh;
        logic c, v;
        mask = (64'd1 << w) - 1;
        hs   = longint'(1) << (w - 1);
        sa   = (a >= longint'(hs)) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = (b >= longint'(hs)) ? longint'(b) - (longint'(1) << w) : longint'(b);
        sh   = int'(b % longint'(w));
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            4'd0: begin r = a + b; c = (r > mask); r = r & mask; s = sa + sb; v = (s > hs - 1) || (s < -hs); end
            4'd1: begin r = (a - b) & mask; c = (a < b); s = sa - sb; v = (s > hs - 1) || (s < -hs); end
            4'd2: r = (a << sh) & mask;
            4'd3: r = (sa < sb) ? 1 : 0;
            4'd4: r = (a < b) ? 1 : 0;
            4'd5: r = a ^ b;
            4'd6: r = a >> sh;
            4'd7: r = longint'(unsigned'(sa >>> sh)) & mask;
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 0;
        endcase
        return {r[63:0], (r >= longint'(hs)), (r == 0), c, v};
    endfunction

    longint unsigned m_regs [32];
    logic            m_valid, m_wen;
    longint unsigned m_res;
    logic [3:0]      m_flags;
    int              m_rd;

    function automatic longint unsigned mfwd(input int r, input logic ret);
        if (r == 0) return 0;
        if (ret && m_wen && m_rd == r) return m_res;
        return m_regs[r];
    endfunction

    // Reference model: architectural registers plus one held result.
    initial begin
        longint unsigned a, b;
        logic [67:0] rr;
        logic ret, iss;
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_valid = 0; m_wen = 0; m_res = 0; m_flags = 0; m_rd = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < 32; i++) m_regs[i] = 0;
                m_valid = 0; m_wen = 0; m_res = 0; m_flags = 0; m_rd = 0;
            end else begin
                ret = m_valid && out_ready;
                iss = in_valid && (!m_valid || out_ready);
                rr  = '0;
                if (iss) begin
                    a  = mfwd(int'(rs1), ret);
                    b  = imm_en ? longint'(imm) : mfwd(int'(rs2), ret);
                    rr = ref_alu(32, alu_op, a, b);
                end
                if (ret && m_wen && m_rd != 0) m_regs[m_rd] = m_res;
                if (iss) begin
                    m_valid = 1; m_res = rr[67:4]; m_flags = rr[3:0];
                    m_rd = int'(rd); m_wen = w_en;
                end else if (ret) begin
                    m_valid = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("cmp_out_valid", 64'(out_valid), 64'(m_valid));
                chk("cmp_in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
                chk("cmp_dbg_data", 64'(dbg_data), m_regs[dbg_addr]);
                if (m_valid) begin
                    chk("cmp_res", 64'(res), m_res);
                    chk("cmp_flags", 64'(flags), 64'(m_flags));
                    chk("cmp_res_rd", 64'(res_rd), 64'(m_rd));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] d, input logic [4:0] a,
                         input logic [4:0] b, input logic ie, input logic [31:0] im);
        alu_op = op; rd = d; rs1 = a; rs2 = b; imm_en = ie; imm = im; w_en = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic s_issue(input logic [3:0] op, input logic [1:0] d, input logic [1:0] a,
                           input logic [7:0] im);
        s_alu_op = op; s_rd = d; s_rs1 = a; s_rs2 = 2'd0; s_imm_en = 1'b1; s_imm = im;
        s_w_en = 1'b1; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    task automatic chk_dbg(input string name, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, 64'(dbg_data), 64'(exp));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; out_ready = 1; alu_op = 0; rs1 = 0; rs2 = 0; rd = 0;
        w_en = 0; imm_en = 0; imm = 0; dbg_addr = 0;
        s_in_valid = 0; s_out_ready = 1; s_alu_op = 0; s_rs1 = 0; s_rs2 = 0; s_rd = 0;
        s_w_en = 0; s_imm_en = 0; s_imm = 0; s_dbg_addr = 0;
        tick(); tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_res", 64'(res), 64'd0);
        chk("reset_flags", 64'(flags), 64'd0);
        rst = 1'b0;
        tick();

        // 8-bit instance
        s_issue(4'd0, 2'd1, 2'd0, 8'hFF);
        chk("s_add_ff", 64'(s_res), 64'hFF);
        s_issue(4'd0, 2'd2, 2'd1, 8'h01);
        chk("s_add_wrap_res", 64'(s_res), 64'h00);
        chk("s_add_wrap_flags", 64'(s_flags), 64'b0110);
        s_issue(4'd12, 2'd3, 2'd1, 8'h03);
        chk("s_undef_res", 64'(s_res), 64'h00);
        chk("s_undef_flags", 64'(s_flags), 64'b0100);
        tick();
        s_dbg_addr = 2'd1;
        #1 chk("s_dbg_r1", 64'(s_dbg_data), 64'hFF);

        // basic write and forwarding chain
        issue(4'd0, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5);
        chk("add_imm5", 64'(res), 64'd5);
        tick();
        chk_dbg("dbg_r1", 5'd1, 32'd5);
        issue(4'd0, 5'd2, 5'd1, 5'd0, 1'b1, 32'd3);
        chk("fwd_add", 64'(res), 64'd8);
        issue(4'd1, 5'd3, 5'd2, 5'd1, 1'b0, 32'd0);
        chk("fwd_sub", 64'(res), 64'd3);
        tick();
        chk_dbg("dbg_r3", 5'd3, 32'd3);

        // flag corners
        issue(4'd0, 5'd4, 5'd0, 5'd0, 1'b1, 32'h7FFFFFFF);
        issue(4'd0, 5'd5, 5'd4, 5'd0, 1'b1, 32'd1);
        chk("ovf_res", 64'(res), 64'h80000000);
        chk("ovf_flags", 64'(flags), 64'b1001);
        issue(4'd0, 5'd6, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF);
        issue(4'd0, 5'd7, 5'd6, 5'd0, 1'b1, 32'd1);
        chk("carry_res", 64'(res), 64'd0);
        chk("carry_flags", 64'(flags), 64'b0110);
        issue(4'd0, 5'd8, 5'd0, 5'd0, 1'b1, 32'd2);
        issue(4'd1, 5'd9, 5'd8, 5'd0, 1'b1, 32'd3);
        chk("borrow_res", 64'(res), 64'hFFFFFFFF);
        chk("borrow_flags", 64'(flags), 64'b1010);
        tick();

        // back-pressure
        out_ready = 1'b0;
        issue(4'd0, 5'd10, 5'd0, 5'd0, 1'b1, 32'h55);
        alu_op = 4'd0; rd = 5'd11; rs1 = 5'd0; imm_en = 1'b1; imm = 32'h66; in_valid = 1'b1;
        dbg_addr = 5'd10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_res_stable", 64'(res), 64'h55);
            chk("bp_no_write", 64'(dbg_data), 64'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_next_issue", 64'(res), 64'h66);
        chk("bp_one_write", 64'(dbg_data), 64'h55);
        tick();
        chk_dbg("bp_dbg_r11", 5'd11, 32'h66);

        // register zero, shifts and compares
        issue(4'd0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h99);
        issue(4'd0, 5'd12, 5'd0, 5'd0, 1'b1, 32'd1);
        chk("x0_no_fwd", 64'(res), 64'd1);
        chk_dbg("x0_dbg", 5'd0, 32'd0);
        issue(4'd0, 5'd13, 5'd0, 5'd0, 1'b1, 32'h80000000);
        issue(4'd7, 5'd14, 5'd13, 5'd0, 1'b1, 32'd31);
        chk("sra31", 64'(res), 64'hFFFFFFFF);
        chk("sra31_flags", 64'(flags), 64'b1000);
        issue(4'd6, 5'd15, 5'd13, 5'd0, 1'b1, 32'd31);
        chk("srl31", 64'(res), 64'd1);
        issue(4'd0, 5'd16, 5'd0, 5'd0, 1'b1, 32'hFFFFFFFF);
        issue(4'd3, 5'd17, 5'd16, 5'd0, 1'b1, 32'd1);
        chk("slt_neg", 64'(res), 64'd1);
        issue(4'd4, 5'd18, 5'd16, 5'd0, 1'b1, 32'd1);
        chk("sltu", 64'(res), 64'd0);
        chk("sltu_flags", 64'(flags), 64'b0100);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            alu_op    = 4'($urandom % 16);
            rd        = 5'($urandom % 8);
            rs1       = 5'($urandom % 8);
            rs2       = 5'($urandom % 8);
            w_en      = ($urandom % 4) != 0;
            imm_en    = $urandom % 2;
            dbg_addr  = 5'($urandom % 8);
            case ($urandom % 4)
                0: imm = $urandom;
                1: imm = 32'h7FFFFFFF;
                2: imm = 32'hFFFFFFFF;
                default: imm = $urandom % 64;
            endcase
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();

        // reset mid-operation drops the held result
        out_ready = 1'b0;
        issue(4'd0, 5'd20, 5'd0, 5'd0, 1'b1, 32'h77);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1 chk("rst_dbg_sweep", 64'(dbg_data), 64'd0);
        end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        issue(4'd0, 5'd1, 5'd0, 5'd0, 1'b1, 32'd5);
        tick();
        chk_dbg("post_rst_r1", 5'd1, 32'd5);
        chk_dbg("post_rst_r20", 5'd20, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
